// File: rtl/i2c_spi_byte_engine.sv
// ----------------------------------------------------------------------------
// i2c_spi_byte_engine
//
// Byte-level SPI master used behind the I2C slave front-end of the
// I2C-to-SPI bridge. Accepts one byte per valid/ready handshake and shifts
// it out MSB-first on mosi_o with a generated sck_o. It returns the byte
// captured from miso_i. Chip-select is held low across bytes until a byte
// marked last has been sent.
//
// Optional feature macro: SPI_MODE_SEL_EN
//   defined   : cpol_i/cpha_i ports exist and all four SPI modes are supported
//   undefined : fixed SPI mode 0 (CPOL=0, CPHA=0) and no mode ports
//
// Parameters
//   CLK_DIV      SCK half-period in clock cycles (1..255)
//
// Ports
//   i2c_wb_clk_i   system clock (rising edge)
//   i2c_wb_rst_i   asynchronous active-low reset
//   cpol_i/cpha_i  SPI mode, sampled on acceptance in IDLE (SPI_MODE_SEL_EN only)
//   tx_data_i      byte to transmit
//   tx_valid_i     tx_data_i/tx_last_i valid
//   tx_last_i      release chip-select after this byte
//   tx_ready_o     engine can accept a byte (IDLE or WAIT)
//   rx_data_o      last byte captured from MISO
//   rx_valid_o     one-cycle pulse when rx_data_o updates
//   busy_o         engine is not IDLE
//   miso_i         SPI data in (already synchronous)
//   sck_o          SPI clock (registered)
//   mosi_o         SPI data out (registered)
//   cs_n_o         SPI chip-select, active low (registered)
// ----------------------------------------------------------------------------
module i2c_spi_byte_engine #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i2c_wb_clk_i,
    input  logic       i2c_wb_rst_i,
`ifdef SPI_MODE_SEL_EN
    input  logic       cpol_i,
    input  logic       cpha_i,
`endif
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       cs_n_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

    logic [2:0] r_state;
    logic [7:0] r_half_cnt;
    logic [4:0] r_edge_cnt;
    logic [7:0] r_shreg;
    logic       r_last;
    logic       r_sck;
    logic       r_mosi;
    logic       r_cs_n;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    logic       w_accept;
    logic       w_half_done;
    logic [4:0] w_edge_next;
    logic       w_sample;
    logic       w_last_edge;
    logic [7:0] w_shreg_next;
    logic       w_cpha;      // phase of the byte in flight
    logic       w_cpha_acc;  // phase that applies to a byte being accepted
    logic       w_cpol_in;   // idle level loaded into sck on IDLE acceptance

`ifdef SPI_MODE_SEL_EN
    logic r_cpha;

    // Mode is captured only when a frame starts from IDLE; in WAIT the
    // frame keeps the mode it started with.
    always_ff @(posedge i2c_wb_clk_i or negedge i2c_wb_rst_i) begin
        if (!i2c_wb_rst_i) begin
            r_cpha <= 1'b0;
        end else if (w_accept && (r_state == S_IDLE)) begin
            r_cpha <= cpha_i;
        end
    end

    assign w_cpha     = r_cpha;
    assign w_cpha_acc = (r_state == S_IDLE) ? cpha_i : r_cpha;
    assign w_cpol_in  = cpol_i;
`else
    assign w_cpha     = 1'b0;
    assign w_cpha_acc = 1'b0;
    assign w_cpol_in  = 1'b0;
`endif

    assign tx_ready_o = (r_state == S_IDLE) || (r_state == S_WAIT);
    assign busy_o     = (r_state != S_IDLE);
    assign w_accept   = tx_valid_i && tx_ready_o;

    assign w_half_done  = (r_half_cnt == '0);
    assign w_edge_next  = r_edge_cnt + 5'd1;
    // Odd edges have bit 0 set: CPHA=0 samples on odd edges, CPHA=1 on even.
    assign w_sample     = w_cpha ? ~w_edge_next[0] : w_edge_next[0];
    assign w_last_edge  = (w_edge_next == 5'd16);
    assign w_shreg_next = w_sample ? {r_shreg[6:0], miso_i} : r_shreg;

    always_ff @(posedge i2c_wb_clk_i or negedge i2c_wb_rst_i) begin
        if (!i2c_wb_rst_i) begin
            r_state    <= S_IDLE;
            r_half_cnt <= '0;
            r_edge_cnt <= '0;
            r_shreg    <= '0;
            r_last     <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (w_accept) begin
                        r_state    <= S_SETUP;
                        r_shreg    <= tx_data_i;
                        r_last     <= tx_last_i;
                        r_half_cnt <= HALF_RELOAD;
                        r_edge_cnt <= '0;
                        r_cs_n     <= 1'b0;
                        if (r_state == S_IDLE) begin
                            r_sck <= w_cpol_in;
                        end
                        if (!w_cpha_acc) begin
                            r_mosi <= tx_data_i[7];
                        end
                    end
                end

                // SETUP ends with SCK edge 1, so both states share the edge
                // logic. After edge 16 of a non-last byte the engine spends
                // one more cycle in SHIFT so that WAIT (and a new acceptance)
                // never overlaps the rx_valid pulse.
                S_SETUP, S_SHIFT: begin
                    if (r_edge_cnt == 5'd16) begin
                        r_state <= S_WAIT;
                    end else if (!w_half_done) begin
                        r_half_cnt <= r_half_cnt - 8'd1;
                    end else begin
                        r_half_cnt <= HALF_RELOAD;
                        r_edge_cnt <= w_edge_next;
                        r_sck      <= ~r_sck;
                        r_shreg    <= w_shreg_next;
                        if (!w_sample && !w_last_edge) begin
                            r_mosi <= r_shreg[7];
                        end
                        if (w_last_edge) begin
                            r_rx_data  <= w_shreg_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= r_last ? S_HOLD : S_SHIFT;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end

                S_HOLD: begin
                    if (w_half_done) begin
                        r_state    <= S_GAP;
                        r_cs_n     <= 1'b1;
                        r_half_cnt <= HALF_RELOAD;
                    end else begin
                        r_half_cnt <= r_half_cnt - 8'd1;
                    end
                end

                S_GAP: begin
                    if (w_half_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_half_cnt <= r_half_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= 1'b1;
                end
            endcase
        end
    end

    assign sck_o      = r_sck;
    assign mosi_o     = r_mosi;
    assign cs_n_o     = r_cs_n;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;

endmodule
